// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// Holds the FSM state encodings and the default parameter values.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2
  } arb_state_e;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned DefCntWidth  = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of eligible at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (!found && eligible[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ write requesters into one shared FIFO write port,
// with back-pressure from fifo_full and a saturating stall counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_we,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          stall_cycles
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CNT_WIDTH-1:0]    stall_q, stall_d;
  logic [NUM_REQ-1:0]      eligible;
  logic [IDX_W-1:0]        winner;
  logic                    found;

  // A requester being acked this cycle still shows req; mask it so it is not granted twice.
  assign eligible = req & ~ack_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .winner   (winner),
    .found    (found)
  );

  always_comb begin
    state_d  = StIdle;
    rr_ptr_d = rr_ptr_q;
    ack_d    = '0;
    we_d     = 1'b0;
    data_d   = data_q;
    stall_d  = stall_q;
    if (found) begin
      if (fifo_full) begin
        state_d = StStall;
        if (stall_q != {CNT_WIDTH{1'b1}}) begin
          stall_d = stall_q + 1'b1;
        end
      end else begin
        state_d  = StRun;
        we_d     = 1'b1;
        ack_d    = NUM_REQ'(1) << winner;
        data_d   = req_data[32'(winner) * DATA_WIDTH +: DATA_WIDTH];
        rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      ack_q    <= '0;
      we_q     <= 1'b0;
      data_q   <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      we_q     <= we_d;
      data_q   <= data_d;
      stall_q  <= stall_d;
    end
  end

  assign ack          = ack_q;
  assign fifo_we      = we_q;
  assign fifo_data    = data_q;
  assign busy         = (state_q != StIdle);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;

  logic [3:0]  ack, ack_s;
  logic        fifo_we, we_s;
  logic [7:0]  fifo_data, data_s;
  logic        busy, busy_s;
  logic [15:0] stall_cycles;
  logic [3:0]  stall_s;

  int checks = 0;
  int errors = 0;

  // Model state: values the outputs should show during the current cycle.
  logic       m_we;
  logic [3:0] m_ack;
  logic [7:0] m_data;
  int         m_ptr;
  logic       m_busy;
  int         m_stall;
  int         m_stall_sat;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .fifo_full    (fifo_full),
    .fifo_we      (fifo_we),
    .fifo_data    (fifo_data),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  fifo_wr_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .CNT_WIDTH  (4)
  ) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack_s),
    .fifo_full    (fifo_full),
    .fifo_we      (we_s),
    .fifo_data    (data_s),
    .busy         (busy_s),
    .stall_cycles (stall_s)
  );

  task automatic model_reset();
    m_we        = 1'b0;
    m_ack       = '0;
    m_data      = '0;
    m_ptr       = 0;
    m_busy      = 1'b0;
    m_stall     = 0;
    m_stall_sat = 0;
  endtask

  // Predict the cycle after the next rising edge from the inputs now applied, then advance.
  task automatic tick();
    logic [3:0] elig;
    bit         any;
    int         win;
    logic       n_we;
    logic [3:0] n_ack;
    logic [7:0] n_data;
    int         n_ptr;
    int         n_stall;
    int         n_stall_sat;
    elig        = req & ~m_ack;
    any         = 1'b0;
    win         = 0;
    n_we        = 1'b0;
    n_ack       = '0;
    n_data      = m_data;
    n_ptr       = m_ptr;
    n_stall     = m_stall;
    n_stall_sat = m_stall_sat;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (!any && elig[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    if (any && !fifo_full) begin
      n_we   = 1'b1;
      n_ack  = 4'b0001 << win;
      n_data = req_data[win*8 +: 8];
      n_ptr  = (win + 1) % 4;
    end
    if (any && fifo_full) begin
      if (n_stall < 65535) n_stall++;
      if (n_stall_sat < 15) n_stall_sat++;
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
    end else begin
      m_we        = n_we;
      m_ack       = n_ack;
      m_data      = n_data;
      m_ptr       = n_ptr;
      m_busy      = any;
      m_stall     = n_stall;
      m_stall_sat = n_stall_sat;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req       = 4'b1111;
    req_data  = 32'hA3A2_A1A0;
    fifo_full = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (fifo_we !== 1'b0 || ack !== 4'b0000 || stall_cycles !== 16'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: we=%b ack=%b stall=%0d busy=%b, want 0/0000/0/0",
                 c, fifo_we, ack, stall_cycles, busy);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      exp_data = 8'hA0 + 8'(c % 4);
      checks++;
      if (fifo_we !== 1'b1 || fifo_data !== exp_data || ack !== (4'b0001 << (c % 4))) begin
        errors++;
        $display("FAIL round_robin cyc%0d: we=%b data=%h ack=%b, want 1/%h/%b",
                 c, fifo_we, fifo_data, ack, exp_data, 4'b0001 << (c % 4));
      end
    end
  endtask

  task automatic test_single_source();
    req = 4'b0000;
    tick();
    tick();
    req                = 4'b0100;
    req_data[23:16]    = 8'h55;
    for (int c = 0; c < 8; c++) begin
      logic exp_we;
      tick();
      exp_we = (c % 2 == 0);
      checks++;
      if (fifo_we !== exp_we || ack !== (exp_we ? 4'b0100 : 4'b0000) ||
          (exp_we && fifo_data !== 8'h55)) begin
        errors++;
        $display("FAIL single_source cyc%0d: we=%b ack=%b data=%h, want we=%b",
                 c, fifo_we, ack, fifo_data, exp_we);
      end
    end
  endtask

  task automatic test_full_stall();
    req       = 4'b0011;
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (fifo_we !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL full_stall cyc%0d: we=%b ack=%b busy=%b, want 0/0000/1",
                 c, fifo_we, ack, busy);
      end
    end
    checks++;
    if (stall_cycles !== 16'd5 || stall_s !== 4'd5) begin
      errors++;
      $display("FAIL stall_count: got %0d/%0d, want 5/5", stall_cycles, stall_s);
    end
    // Last grant was requester 2, so the pointer sits at 3 and wraps to requester 0.
    fifo_full = 1'b0;
    tick();
    checks++;
    if (fifo_we !== 1'b1 || ack !== 4'b0001 || fifo_data !== 8'hA0) begin
      errors++;
      $display("FAIL stall_resume: we=%b ack=%b data=%h, want 1/0001/a0",
               fifo_we, ack, fifo_data);
    end
  endtask

  task automatic test_saturation();
    fifo_full = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    checks++;
    if (stall_s !== 4'd15 || stall_cycles !== 16'(m_stall)) begin
      errors++;
      $display("FAIL saturation: sat=%0d wide=%0d, want 15/%0d", stall_s, stall_cycles, m_stall);
    end
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (stall_s !== 4'd15) begin
      errors++;
      $display("FAIL saturation_hold: sat=%0d, want 15", stall_s);
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    req      = 4'b1111;
    req_data = 32'hA3A2_A1A0;
    tick();
    tick();
    checks++;
    if (fifo_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_setup: we=%b, want 1", fifo_we);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (fifo_we !== 1'b0 || ack !== 4'b0000 || fifo_data !== 8'h00 ||
        we_s !== 1'b0 || ack_s !== 4'b0000 || stall_s !== 4'd0 || stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: we=%b ack=%b data=%h stall=%0d sat=%0d, want all zero",
               fifo_we, ack, fifo_data, stall_cycles, stall_s);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    checks++;
    if (fifo_we !== 1'b1 || ack !== 4'b0001 || fifo_data !== 8'hA0) begin
      errors++;
      $display("FAIL reset_ptr: we=%b ack=%b data=%h, want 1/0001/a0", fifo_we, ack, fifo_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else req_data[i*8 +: 8] = 8'($urandom);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]             = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (fifo_we !== m_we || ack !== m_ack || fifo_data !== m_data || busy !== m_busy ||
          stall_cycles !== 16'(m_stall)) begin
        errors++;
        $display("FAIL random cyc%0d: we=%b ack=%b data=%h busy=%b stall=%0d, want %b/%b/%h/%b/%0d",
                 c, fifo_we, ack, fifo_data, busy, stall_cycles,
                 m_we, m_ack, m_data, m_busy, m_stall);
      end
      checks++;
      if (we_s !== m_we || ack_s !== m_ack || data_s !== m_data || busy_s !== m_busy ||
          stall_s !== 4'(m_stall_sat)) begin
        errors++;
        $display("FAIL random_sat cyc%0d: we=%b ack=%b data=%h stall=%0d, want %b/%b/%h/%0d",
                 c, we_s, ack_s, data_s, stall_s, m_we, m_ack, m_data, m_stall_sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_source();
    test_full_stall();
    test_saturation();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
